divisor_frecuencia_prog: RTL and testbench
==========================================

Name: divisor_frecuencia_prog

Overview:
- Parametrised, runtime-programmable, multi-channel successor to the fixed 100 MHz divider.
- Each of NUM_CH channels divides clk by a programmable half-period and produces two outputs:
  - a 50 % duty square output;
  - a one-cycle tick strobe, usable as a clock enable.
- New half-periods are written through a simple write port. They take effect only at a period boundary, so outputs never glitch.
- Shared enable and sync inputs freeze all channels or phase-align them.
- Feeds the RTC/VGA control state machines with slow clocks and enables.

Parameters:
- NUM_CH, 2, number of independent divider channels (>=1).
- WIDTH, 26, width of the half-period value and of each channel counter.
- RESET_HALF, 50_000_000, half-period loaded into every channel at reset (100 MHz -> 1 Hz).
- CH_W, max(1,$clog2(NUM_CH)), derived width of the channel index (localparam).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous reset, active-low.
- en  in  1  count enable. When low, counters and outputs hold.
- sync  in  1  one-cycle phase-align strobe for all channels.
- cfg_we  in  1  write strobe for a new half-period.
- cfg_ch  in  CH_W  target channel index for cfg_we.
- cfg_half  in  WIDTH  new half-period in clk cycles.
- clk_out  out  NUM_CH  per-channel divided square output, registered.
- tick  out  NUM_CH  per-channel one-cycle strobe on each clk_out rising transition, registered.
- cfg_pend  out  NUM_CH  per-channel flag: a written value is waiting to be applied.

Behaviour:
- Per-channel state: counter[WIDTH], active half A, pending half P, pending flag.
- Effective half: E = (A==0) ? 1 : A. A value of 0 behaves as 1, so clk_out toggles every enabled cycle.
- Reset (rst low, asynchronous, any time including mid-period):
  - counter=0, clk_out=0, tick=0, cfg_pend=0;
  - A=P=RESET_HALF.
- Counting, each rising clk edge with en=1 and sync=0:
  - If counter==E-1: counter<=0, clk_out toggles, and A<=P if cfg_pend is set (cfg_pend then clears).
  - Otherwise counter<=counter+1.
- Timing after reset or sync:
  - First clk_out rise occurs on the E-th enabled edge.
  - High time is E enabled cycles, low time is E enabled cycles, so the period is 2E.
- tick: asserted on exactly the edge where clk_out registers 0->1, for one cycle. It is 0 in all other cycles, including every cycle with en=0.
- en=0: counter, clk_out and A hold. tick=0. Config writes are still accepted.
- sync=1, which has priority over en and acts even when en=0:
  - all channels: counter<=0, clk_out<=0, tick<=0;
  - any channel with cfg_pend set applies P immediately and clears its flag.
  - Counting resumes from 0 on the next enabled edge.
- Config write (cfg_we=1):
  - P[cfg_ch]<=cfg_half and cfg_pend[cfg_ch]<=1.
  - A second write before application overwrites P (last write wins).
  - cfg_ch >= NUM_CH: write ignored, no state changes.
- Write coincident with wrap on the same channel: the new cfg_half is applied at that wrap; cfg_pend ends 0.
- Write coincident with sync: the new cfg_half is applied by the sync; cfg_pend ends 0.
- Channels are fully independent except for the shared en, sync and rst.
- Counter never exceeds E-1, because A only changes while counter is 0. No wrap-around of the WIDTH counter is possible.

Test Plan:
- Reset with RESET_HALF overridden to 3, en=1 -> ch0:
  - clk_out rises on the 3rd edge, falls on the 6th, period 6;
  - tick high only on edges 3, 9, 15.
- Write cfg_ch=1, cfg_half=5 at counter 1 of a 3-cycle half -> cfg_pend[1]=1 until the next wrap, then period becomes 10; ch0 unaffected.
- cfg_half=0 on ch0 -> after the boundary, clk_out toggles every cycle and tick is high every 2nd cycle.
- en low for 4 cycles mid-high phase -> clk_out stays 1, counter holds, tick=0; the high phase resumes and totals E enabled cycles.
- sync pulse with different phases on ch0/ch1, en=0 -> both clk_out=0 next cycle. The pending value is applied. After en=1, both rise together after E cycles.
- rst asserted mid-count, asynchronously between edges -> all outputs 0 immediately. cfg_ch=2 with NUM_CH=2 -> no change to any channel.

Source files
------------

// File: rtl/divisor_frecuencia_prog.sv
// Multi-channel programmable clock divider: each channel emits a 50% square
// output and a one-cycle tick on every rising transition of that output.

module divisor_frecuencia_prog_ch #(
    parameter int unsigned WIDTH      = 26,
    parameter int unsigned RESET_HALF = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_half,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);
    logic [WIDTH-1:0] cnt, act, pnd, last;
    logic             wrap;

    // Half-period 0 behaves like 1, so the terminal count is 0 in both cases.
    assign last = (act == '0) ? '0 : act - WIDTH'(1);
    assign wrap = (cnt == last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            act     <= WIDTH'(RESET_HALF);
            pnd     <= WIDTH'(RESET_HALF);
            pend    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (wr)
                pnd <= wr_half;
            if (sync) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                if (wr) begin
                    act  <= wr_half;
                    pend <= 1'b0;
                end else if (pend) begin
                    act  <= pnd;
                    pend <= 1'b0;
                end
            end else if (en && wrap) begin
                // Half-period boundary: the only point where the active value may change.
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
                if (wr) begin
                    act  <= wr_half;
                    pend <= 1'b0;
                end else if (pend) begin
                    act  <= pnd;
                    pend <= 1'b0;
                end
            end else begin
                if (en)
                    cnt <= cnt + WIDTH'(1);
                if (wr)
                    pend <= 1'b1;
            end
        end
    end
endmodule

module divisor_frecuencia_prog #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned WIDTH      = 26,
    parameter int unsigned RESET_HALF = 50_000_000,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pend
);
    // Out-of-range indices never match any channel, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        divisor_frecuencia_prog_ch #(
            .WIDTH      (WIDTH),
            .RESET_HALF (RESET_HALF)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .sync    (sync),
            .wr      (cfg_we && (cfg_ch == CH_W'(i))),
            .wr_half (cfg_half),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (cfg_pend[i])
        );
    end
endmodule

// File: tb/tb_divisor_frecuencia_prog.sv
// Randomized bench for divisor_frecuencia_prog against a period-position model.

module tb_divisor_frecuencia_prog;
    localparam int NC = 3;
    localparam int W  = 8;
    localparam int RH = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst, en, sync, cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_half;
    logic [NC-1:0] clk_out, tick, cfg_pend;

    divisor_frecuencia_prog #(.NUM_CH(NC), .WIDTH(W), .RESET_HALF(RH)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_half(cfg_half),
        .clk_out(clk_out), .tick(tick), .cfg_pend(cfg_pend)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: position inside the full period (0..2E-1); output is high in the upper half.
    int pos[NC];
    int act[NC];
    int pnd[NC];
    bit pend[NC];
    bit tk[NC];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int a);
        return (a == 0) ? 1 : a;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            pos[c] = 0; act[c] = RH; pnd[c] = RH; pend[c] = 0; tk[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NC; c++) begin
            bit w;
            int e;
            w = cfg_we && (int'(cfg_ch) == c);
            e = eff(act[c]);
            tk[c] = 0;
            if (sync) begin
                pos[c] = 0;
                if (w) begin act[c] = cfg_half; pnd[c] = cfg_half; pend[c] = 0; end
                else if (pend[c]) begin act[c] = pnd[c]; pend[c] = 0; end
            end else if (en) begin
                pos[c]++;
                tk[c] = (pos[c] == e);
                if (pos[c] == e || pos[c] == 2 * e) begin
                    if (pos[c] == 2 * e) pos[c] = 0;
                    if (w) begin act[c] = cfg_half; pnd[c] = cfg_half; pend[c] = 0; end
                    else if (pend[c]) begin act[c] = pnd[c]; pend[c] = 0; end
                    if (pos[c] != 0) pos[c] = eff(act[c]);
                end else if (w) begin
                    pnd[c] = cfg_half; pend[c] = 1;
                end
            end else if (w) begin
                pnd[c] = cfg_half; pend[c] = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NC-1:0] eo, et, ep;
        for (int c = 0; c < NC; c++) begin
            eo[c] = (pos[c] >= eff(act[c]));
            et[c] = tk[c];
            ep[c] = pend[c];
        end
        chk({tag, "_clk_out"}, int'(clk_out), int'(eo));
        chk({tag, "_tick"}, int'(tick), int'(et));
        chk({tag, "_pend"}, int'(cfg_pend), int'(ep));
    endtask

    task automatic step(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_pend", int'(cfg_pend), 0);
        model_reset();
        #2 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
        #12;
        chk("init_clk_out", int'(clk_out), 0);
        chk("init_tick", int'(tick), 0);
        chk("init_pend", int'(cfg_pend), 0);
        model_reset();
        rst = 1'b1;

        // Half-period 3 from reset: rise on edge 3, fall on 6, ticks on 3/9/15.
        en = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            step("base", 1);
            chk("base_ch0_out", int'(clk_out[0]), (n / 3) % 2);
            chk("base_ch0_tick", int'(tick[0]), (n % 6 == 3) ? 1 : 0);
        end

        // Write ch1 while its counter is 1: stays pending until the next wrap.
        step("pre_wr", 1);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd5;
        step("wr_ch1", 1);
        cfg_we = 1'b0;
        chk("wr_ch1_pending", int'(cfg_pend[1]), 1);
        step("run_ch1", 24);

        // Half-period 0 behaves as 1.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd0;
        step("wr_zero", 1);
        cfg_we = 1'b0;
        step("run_zero", 12);

        // Pause in the middle of a high phase.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd4;
        step("wr_four", 1);
        cfg_we = 1'b0;
        step("run_four", 8);
        for (int k = 0; k < 20 && !(clk_out[0] && !tick[0]); k++) step("seek_high", 1);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step("hold", 1);
            chk("hold_out0", int'(clk_out[0]), 1);
            chk("hold_tick", int'(tick), 0);
        end
        en = 1'b1;
        step("resume", 10);

        // Sync while disabled applies pending values and aligns phases.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd2;
        en = 1'b0;
        step("sync_wr0", 1);
        cfg_ch = 2'd1;
        sync = 1'b1;
        step("sync", 1);
        sync = 1'b0; cfg_we = 1'b0;
        chk("sync_out", int'(clk_out), 0);
        chk("sync_pend", int'(cfg_pend), 0);
        en = 1'b1;
        step("sync_run", 1);
        chk("sync_low01", int'(clk_out[1:0]), 0);
        step("sync_run", 1);
        chk("sync_rise01", int'(clk_out[1:0]), 3);
        step("sync_run", 6);

        // Asynchronous reset mid-count, then a write to a nonexistent channel.
        async_reset();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd1;
        step("bad_ch", 1);
        cfg_we = 1'b0;
        chk("bad_ch_pend", int'(cfg_pend), 0);
        step("bad_ch_run", 8);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom % 8) != 0;
            sync     = ($urandom % 40) == 0;
            cfg_we   = ($urandom % 6) == 0;
            cfg_ch   = CW'($urandom % 4);
            cfg_half = W'($urandom % 7);
            if (($urandom % 700) == 0) begin
                en = 1'b1; sync = 1'b0; cfg_we = 1'b0;
                async_reset();
            end
            step("rnd", 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
